// File: rtl/lcd_spi_rx_decoder_if.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx_decoder_if
//   The 4-wire serial LCD link between the LCD controller and the panel.
//   Signals:
//     cs_lcd   chip select, active low
//     scl_lcd  serial clock
//     sda_lcd  serial data, MSB first
//     rs_lcd   0 = command byte, 1 = parameter/data byte
//   Modports:
//     master   the controller side, which drives every line
//     slave    the panel side (lcd_spi_rx_decoder), which only observes
// -----------------------------------------------------------------------------
interface lcd_spi_rx_decoder_if;
    logic cs_lcd;
    logic scl_lcd;
    logic sda_lcd;
    logic rs_lcd;

    modport master (
        output cs_lcd,
        output scl_lcd,
        output sda_lcd,
        output rs_lcd
    );

    modport slave (
        input cs_lcd,
        input scl_lcd,
        input sda_lcd,
        input rs_lcd
    );
endinterface

// File: rtl/lcd_spi_rx_decoder.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx_decoder
//   Panel-side receiver for the 4-wire serial LCD link. It deserialises
//   9-bit transfers (rs plus 8 data bits) and decodes column address (0x2A),
//   page address (0x2B) and memory write (0x2C). It emits addressed RGB565
//   pixel writes with a cursor that walks the programmed window.
//
//   Optional feature (macro LCD_RX_PIXCNT_EN):
//     defined   - pix_count is a saturating 18-bit count of the pixels
//                 written since the last 0x2C
//     undefined - pix_count is tied to zero and no counter is built
//
//   Ports:
//     clk          system clock, at least 4x the scl rate
//     rstn         asynchronous active-low reset
//     lcd          serial link (slave modport: cs/scl/sda/rs)
//     byte_valid   one-cycle pulse: a byte was received
//     byte_data    received byte, held until the next byte_valid
//     byte_is_data rs value latched with byte_data
//     cmd_valid    one-cycle pulse for every command byte
//     pix_valid    one-cycle pulse: pixel write
//     pix_x/pix_y  pixel column/row, valid with pix_valid
//     pix_rgb      RGB565 pixel {high byte, low byte}
//     frame_done   pulses with the last pixel of the window
//     error        one-cycle pulse: cs rose while a byte was partial
//     pix_count    pixels written since the last 0x2C (optional)
// -----------------------------------------------------------------------------
module lcd_spi_rx_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int X_END_DEF   = 239,
    parameter int Y_END_DEF   = 319
) (
    input  logic                      clk,
    input  logic                      rstn,
    lcd_spi_rx_decoder_if.slave       lcd,
    output logic                      byte_valid,
    output logic [DATA_WIDTH-1:0]     byte_data,
    output logic                      byte_is_data,
    output logic                      cmd_valid,
    output logic                      pix_valid,
    output logic [ADDR_WIDTH-1:0]     pix_x,
    output logic [ADDR_WIDTH-1:0]     pix_y,
    output logic [2*DATA_WIDTH-1:0]   pix_rgb,
    output logic                      frame_done,
    output logic                      error,
    output logic [17:0]               pix_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] CMD_CASET = DATA_WIDTH'(8'h2A);
    localparam logic [DATA_WIDTH-1:0] CMD_PASET = DATA_WIDTH'(8'h2B);
    localparam logic [DATA_WIDTH-1:0] CMD_RAMWR = DATA_WIDTH'(8'h2C);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_OTHER = 3'd4
    } state_t;

    // Replace the upper byte of a 16-bit window value, keeping only the low ADDR_WIDTH bits
    function automatic logic [ADDR_WIDTH-1:0] set_hi(input logic [ADDR_WIDTH-1:0] cur,
                                                     input logic [DATA_WIDTH-1:0] b);
        set_hi = ADDR_WIDTH'({b, DATA_WIDTH'(cur)});
    endfunction

    // Replace the lower byte of a 16-bit window value, keeping only the low ADDR_WIDTH bits
    function automatic logic [ADDR_WIDTH-1:0] set_lo(input logic [ADDR_WIDTH-1:0] cur,
                                                     input logic [DATA_WIDTH-1:0] b);
        set_lo = ADDR_WIDTH'({cur >> DATA_WIDTH, b});
    endfunction

    // ---------------------------------------------------------------- front end
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic                   scl_prev_q;
    logic                   cs_s;
    logic                   scl_s;
    logic                   sda_s;
    logic                   rs_s;
    logic                   scl_rise_s;

    // Bring the asynchronous link lines into the clk domain; cs idles deselected
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_sync_q  <= {SYNC_STAGES{1'b1}};
            scl_sync_q <= {SYNC_STAGES{1'b0}};
            sda_sync_q <= {SYNC_STAGES{1'b0}};
            rs_sync_q  <= {SYNC_STAGES{1'b0}};
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0],  lcd.cs_lcd};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], lcd.scl_lcd};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], lcd.sda_lcd};
            rs_sync_q  <= {rs_sync_q[SYNC_STAGES-2:0],  lcd.rs_lcd};
        end
    end

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign rs_s       = rs_sync_q[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_q;

    // The last bit of each byte is taken straight from sda, so the shifter
    // only has to hold the first DATA_WIDTH-1 bits.
    logic [DATA_WIDTH-2:0]  shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   byte_valid_q;
    logic [DATA_WIDTH-1:0]  byte_data_q;
    logic                   byte_is_data_q;
    logic                   error_q;

    // Shift serial bits in on scl rising edges and present complete bytes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_prev_q     <= 1'b0;
            shift_q        <= {(DATA_WIDTH-1){1'b0}};
            bit_cnt_q      <= CNT_ZERO;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= DATA_ZERO;
            byte_is_data_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            scl_prev_q   <= scl_s;
            byte_valid_q <= 1'b0;
            error_q      <= 1'b0;
            if (cs_s) begin
                // Deselect: a non-zero count here means the byte was cut short
                bit_cnt_q <= CNT_ZERO;
                if (bit_cnt_q != CNT_ZERO) begin
                    error_q <= 1'b1;
                end
            end else if (scl_rise_s) begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q      <= CNT_ZERO;
                    byte_valid_q   <= 1'b1;
                    byte_data_q    <= {shift_q, sda_s};
                    byte_is_data_q <= rs_s;
                end else begin
                    shift_q   <= {shift_q[DATA_WIDTH-3:0], sda_s};
                    bit_cnt_q <= bit_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // ---------------------------------------------------------------- decoder
    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   xs_q, xs_d, xe_q, xe_d;
    logic [ADDR_WIDTH-1:0]   ys_q, ys_d, ye_q, ye_d;
    logic [ADDR_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic                    half_q, half_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    pix_valid_q, pix_valid_d;
    logic [ADDR_WIDTH-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [2*DATA_WIDTH-1:0] pix_rgb_q, pix_rgb_d;
    logic                    frame_done_q, frame_done_d;
    logic                    at_x_end_s, at_y_end_s;

    assign at_x_end_s = (x_q == xe_q);
    assign at_y_end_s = (y_q == ye_q);

    // Decoder next state: command dispatch, window programming and pixel cursor
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        half_d       = half_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        frame_done_d = 1'b0;

        if (byte_valid_q) begin
            if (!byte_is_data_q) begin
                // Any command aborts whatever was in progress, including a half pixel
                cmd_valid_d = 1'b1;
                idx_d       = 2'd0;
                half_d      = 1'b0;
                case (byte_data_q)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_PASET: state_d = ST_PASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    default:   state_d = ST_OTHER;
                endcase
            end else begin
                case (state_q)
                    ST_CASET: begin
                        case (idx_q)
                            2'd0:    xs_d = set_hi(xs_q, byte_data_q);
                            2'd1:    xs_d = set_lo(xs_q, byte_data_q);
                            2'd2:    xe_d = set_hi(xe_q, byte_data_q);
                            default: xe_d = set_lo(xe_q, byte_data_q);
                        endcase
                        if (idx_q == 2'd3) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    ST_PASET: begin
                        case (idx_q)
                            2'd0:    ys_d = set_hi(ys_q, byte_data_q);
                            2'd1:    ys_d = set_lo(ys_q, byte_data_q);
                            2'd2:    ye_d = set_hi(ye_q, byte_data_q);
                            default: ye_d = set_lo(ye_q, byte_data_q);
                        endcase
                        if (idx_q == 2'd3) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    ST_RAMWR: begin
                        if (!half_q) begin
                            hi_d   = byte_data_q;
                            half_d = 1'b1;
                        end else begin
                            pix_valid_d  = 1'b1;
                            pix_x_d      = x_q;
                            pix_y_d      = y_q;
                            pix_rgb_d    = {hi_q, byte_data_q};
                            frame_done_d = at_x_end_s & at_y_end_s;
                            half_d       = 1'b0;
                            // Wrap only on equality; a start beyond end runs through 9-bit rollover
                            if (at_x_end_s) begin
                                x_d = xs_q;
                                if (at_y_end_s) begin
                                    y_d = ys_q;
                                end else begin
                                    y_d = y_q + ADDR_ONE;
                                end
                            end else begin
                                x_d = x_q + ADDR_ONE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and OTHER ignore data bytes
                        state_d = state_q;
                    end
                endcase
            end
        end else begin
            // No byte this cycle: hold everything
            state_d = state_q;
        end
    end

    // Decoder state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            xs_q         <= ADDR_ZERO;
            xe_q         <= ADDR_WIDTH'(X_END_DEF);
            ys_q         <= ADDR_ZERO;
            ye_q         <= ADDR_WIDTH'(Y_END_DEF);
            x_q          <= ADDR_ZERO;
            y_q          <= ADDR_ZERO;
            half_q       <= 1'b0;
            hi_q         <= DATA_ZERO;
            cmd_valid_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= ADDR_ZERO;
            pix_y_q      <= ADDR_ZERO;
            pix_rgb_q    <= {(2*DATA_WIDTH){1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            half_q       <= half_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LCD_RX_PIXCNT_EN
    logic [17:0] pix_count_q;
    logic        cnt_clr_s;

    assign cnt_clr_s = byte_valid_q & ~byte_is_data_q & (byte_data_q == CMD_RAMWR);

    // Saturating pixel counter; it advances in step with pix_valid so the count includes that pixel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_count_q <= 18'd0;
        end else if (cnt_clr_s) begin
            pix_count_q <= 18'd0;
        end else if (pix_valid_d && (pix_count_q != 18'h3FFFF)) begin
            pix_count_q <= pix_count_q + 18'd1;
        end
    end

    assign pix_count = pix_count_q;
`else
    assign pix_count = 18'd0;
`endif

    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_data = byte_is_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_rgb      = pix_rgb_q;
    assign frame_done   = frame_done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx_decoder
//   Drives the serial link with directed and randomized transfers and checks
//   every received byte and pixel against a reference model of the panel's
//   command set (window parameters kept as bytes, cursor as integers).
// -----------------------------------------------------------------------------
module tb_lcd_spi_rx_decoder;

    logic        clk;
    logic        rstn;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic        cmd_valid;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_rgb;
    logic        frame_done;
    logic        error;
    logic [17:0] pix_count;

    lcd_spi_rx_decoder_if lcd_if ();

    lcd_spi_rx_decoder dut (
        .clk          (clk),
        .rstn         (rstn),
        .lcd          (lcd_if.slave),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .cmd_valid    (cmd_valid),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_rgb      (pix_rgb),
        .frame_done   (frame_done),
        .error        (error),
        .pix_count    (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    typedef struct {
        int          x;
        int          y;
        logic [15:0] rgb;
        bit          fd;
        int          cnt;
    } pix_t;
    typedef struct {
        logic       rs;
        logic [7:0] d;
    } byte_t;

    pix_t  exp_q[$];
    byte_t exp_b[$];

    int   m_mode;   // 0 idle/other, 1 column, 2 page, 3 memory write
    int   m_idx;
    int   xp[4];
    int   yp[4];
    int   m_xs, m_xe, m_ys, m_ye, m_x, m_y;
    bit   m_half;
    logic [7:0] m_hi;
    int   m_cnt;
    int   m_cmds;

    task automatic model_reset();
        m_mode = 0; m_idx = 0;
        xp[0] = 0; xp[1] = 0; xp[2] = 0; xp[3] = 239;
        yp[0] = 0; yp[1] = 0; yp[2] = 1; yp[3] = 63;
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_x = 0; m_y = 0; m_half = 1'b0; m_hi = 8'h00; m_cnt = 0;
        exp_q.delete();
        exp_b.delete();
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] d);
        pix_t p;
        if (!rs) begin
            m_cmds++;
            m_idx = 0;
            m_half = 1'b0;
            if (d == 8'h2A)      m_mode = 1;
            else if (d == 8'h2B) m_mode = 2;
            else if (d == 8'h2C) begin
                m_mode = 3; m_x = m_xs; m_y = m_ys; m_cnt = 0;
            end else             m_mode = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_mode == 1) xp[m_idx] = int'(d); else yp[m_idx] = int'(d);
            m_xs = ((xp[0] * 256) + xp[1]) % 512;
            m_xe = ((xp[2] * 256) + xp[3]) % 512;
            m_ys = ((yp[0] * 256) + yp[1]) % 512;
            m_ye = ((yp[2] * 256) + yp[3]) % 512;
            m_idx++;
            if (m_idx == 4) m_mode = 0;
        end else if (m_mode == 3) begin
            if (!m_half) begin
                m_hi = d; m_half = 1'b1;
            end else begin
                m_half = 1'b0;
                if (m_cnt < 262143) m_cnt++;
                p.x = m_x; p.y = m_y; p.rgb = {m_hi, d};
                p.fd = (m_x == m_xe) && (m_y == m_ye);
                p.cnt = m_cnt;
                exp_q.push_back(p);
                if (m_x == m_xe) begin
                    m_x = m_xs;
                    m_y = (m_y == m_ye) ? m_ys : (m_y + 1) % 512;
                end else begin
                    m_x = (m_x + 1) % 512;
                end
            end
        end
    endtask

    // ---------------------------------------------------------- monitor
    int obs_bytes, obs_cmds, obs_pix, obs_fd, obs_err;
    int last_x, last_y, fd_x, fd_y;
    logic [15:0] last_rgb;
    logic [7:0]  last_byte;

    always @(negedge clk) begin
        pix_t  p;
        byte_t b;
        if (rstn) begin
            if (byte_valid) begin
                obs_bytes++;
                last_byte = byte_data;
                if (exp_b.size() == 0) begin
                    chk("byte_unexpected", 64'd1, 64'd0);
                end else begin
                    b = exp_b.pop_front();
                    chk("byte_data", 64'(byte_data), 64'(b.d));
                    chk("byte_is_data", 64'(byte_is_data), 64'(b.rs));
                end
            end
            if (cmd_valid) obs_cmds++;
            if (error) obs_err++;
            if (frame_done && !pix_valid) chk("fd_without_pix", 64'd1, 64'd0);
            if (pix_valid) begin
                obs_pix++;
                last_x = int'(pix_x); last_y = int'(pix_y); last_rgb = pix_rgb;
                if (frame_done) begin
                    obs_fd++; fd_x = int'(pix_x); fd_y = int'(pix_y);
                end
                if (exp_q.size() == 0) begin
                    chk("pix_unexpected", 64'd1, 64'd0);
                end else begin
                    p = exp_q.pop_front();
                    chk("pix_xy", {32'(pix_x), 32'(pix_y)}, {32'(p.x), 32'(p.y)});
                    chk("pix_rgb", 64'(pix_rgb), 64'(p.rgb));
                    chk("pix_fd", 64'(frame_done), 64'(p.fd));
`ifdef LCD_RX_PIXCNT_EN
                    chk("pix_count", 64'(pix_count), 64'(p.cnt));
`else
                    chk("pix_count_tied", 64'(pix_count), 64'd0);
`endif
                end
            end
        end
    end

    // ---------------------------------------------------------- drivers
    task automatic send_bits(input logic rs, input logic [7:0] d, input int nbits);
        if (lcd_if.cs_lcd) begin
            @(negedge clk);
            lcd_if.cs_lcd = 1'b0;
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            lcd_if.sda_lcd = d[7 - i];
            lcd_if.rs_lcd  = rs;
            repeat (3) @(negedge clk);
            lcd_if.scl_lcd = 1'b1;
            repeat (3) @(negedge clk);
            lcd_if.scl_lcd = 1'b0;
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d);
        byte_t b;
        b.rs = rs; b.d = d;
        exp_b.push_back(b);
        model_byte(rs, d);
        send_bits(rs, d, 8);
    endtask

    task automatic cs_gap();
        @(negedge clk);
        lcd_if.cs_lcd = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {byte_valid, byte_is_data, cmd_valid, pix_valid, frame_done, error,
                  byte_data, pix_rgb}, 64'd0);
        chk(tag, {pix_x, pix_y, pix_count}, 64'd0);
    endtask

    // ---------------------------------------------------------- stimulus
    int p0, f0, c0, e0, b0;
    logic [7:0] d2, d3, r8;

    initial begin
        n_tests = 0; n_fail = 0;
        obs_bytes = 0; obs_cmds = 0; obs_pix = 0; obs_fd = 0; obs_err = 0; m_cmds = 0;
        last_x = 0; last_y = 0; fd_x = 0; fd_y = 0; last_rgb = 16'h0; last_byte = 8'h00;
        lcd_if.cs_lcd = 1'b1; lcd_if.scl_lcd = 1'b0; lcd_if.sda_lcd = 1'b0; lcd_if.rs_lcd = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: default window, two pixels
        p0 = obs_pix;
        d2 = 8'($urandom); d3 = 8'($urandom);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom));
        send_byte(1'b1, d2); send_byte(1'b1, d3);
        settle();
        chk("t1_npix", 64'(obs_pix - p0), 64'd2);
        chk("t1_last_xy", {32'(last_x), 32'(last_y)}, {32'd1, 32'd0});
        chk("t1_last_rgb", 64'(last_rgb), 64'({d2, d3}));

        // 2: 2x2 window, frame_done on the 4th pixel only
        p0 = obs_pix; f0 = obs_fd;
        send_byte(1'b0, 8'h2A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
        cs_gap();
        send_byte(1'b0, 8'h2B); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 8; i++) send_byte(1'b1, 8'($urandom));
        settle();
        chk("t2_npix", 64'(obs_pix - p0), 64'd4);
        chk("t2_nfd", 64'(obs_fd - f0), 64'd1);
        chk("t2_fd_xy", {32'(fd_x), 32'(fd_y)}, {32'd1, 32'd1});

        // 3: single-pixel window, every pixel ends a frame
        p0 = obs_pix; f0 = obs_fd;
        send_byte(1'b0, 8'h2A);
        for (int i = 0; i < 4; i++) send_byte(1'b1, 8'h00);
        send_byte(1'b0, 8'h2B);
        for (int i = 0; i < 4; i++) send_byte(1'b1, 8'h00);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
        settle();
        chk("t3_npix", 64'(obs_pix - p0), 64'd2);
        chk("t3_nfd", 64'(obs_fd - f0), 64'd2);
        chk("t3_rgb", 64'(last_rgb), 64'h0000_0000_0000_F800);

        // 4: command aborts a half pixel; data afterwards is ignored
        p0 = obs_pix; c0 = obs_cmds;
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'hF8);
        send_byte(1'b0, 8'h29); send_byte(1'b1, 8'h00);
        settle();
        chk("t4_npix", 64'(obs_pix - p0), 64'd0);
        chk("t4_ncmd", 64'(obs_cmds - c0), 64'd2);

        // 5: partial byte then a full byte
        e0 = obs_err; b0 = obs_bytes;
        send_bits(1'b1, 8'h3C, 5);
        cs_gap();
        settle();
        chk("t5_error", 64'(obs_err - e0), 64'd1);
        chk("t5_no_byte", 64'(obs_bytes - b0), 64'd0);
        send_byte(1'b1, 8'hA5);
        settle();
        chk("t5_byte", 64'(last_byte), 64'hA5);
        chk("t5_nbyte", 64'(obs_bytes - b0), 64'd1);

        // 6: pixel counter follows 0x2C
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 6; i++) send_byte(1'b1, 8'($urandom));
        settle();
`ifdef LCD_RX_PIXCNT_EN
        chk("t6_count3", 64'(pix_count), 64'd3);
`else
        chk("t6_count_tied", 64'(pix_count), 64'd0);
`endif
        send_byte(1'b0, 8'h2C);
        settle();
        chk("t6_count_clr", 64'(pix_count), 64'd0);

        // Randomized traffic, including reversed windows and cs toggles between bytes
        e0 = obs_err;
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 11));
            r8 = 8'($urandom);
            if (r == 0)      send_byte(1'b0, 8'h2A);
            else if (r == 1) send_byte(1'b0, 8'h2B);
            else if (r == 2) send_byte(1'b0, 8'h2C);
            else if (r == 3) send_byte(1'b0, r8);
            else if (r == 4) send_byte(1'b1, r8 & 8'h01);
            else             send_byte(1'b1, r8);
            if ($urandom_range(0, 7) == 0) cs_gap();
        end
        settle();
        chk("rand_pix_left", 64'(exp_q.size()), 64'd0);
        chk("rand_byte_left", 64'(exp_b.size()), 64'd0);
        chk("rand_cmds", 64'(obs_cmds), 64'(m_cmds));
        chk("rand_no_error", 64'(obs_err - e0), 64'd0);

        // Reset in the middle of a byte
        send_bits(1'b1, 8'($urandom), 4);
        #3 rstn = 1'b0;
        lcd_if.cs_lcd = 1'b1; lcd_if.scl_lcd = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs("midreset_outputs");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        p0 = obs_pix; e0 = obs_err;
        send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
        settle();
        chk("post_reset_npix", 64'(obs_pix - p0), 64'd1);
        chk("post_reset_xy", {32'(last_x), 32'(last_y)}, {32'd0, 32'd0});
        chk("post_reset_rgb", 64'(last_rgb), 64'h1234);
        chk("post_reset_no_error", 64'(obs_err - e0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
